lh_digest_hex_reader: RTL and testbench

Consumer at the output end of the light hash core. Captures each 64-bit digest when `digest_ready` is asserted and streams it out as ASCII hexadecimal characters, most significant nibble first, over a valid/ready byte interface. An optional line-feed terminator follows each digest. The block feeds digest text into character-oriented sinks such as a UART transmitter or a bench file writer.

---
 rtl/lh_pkg.sv | 22 ++
 rtl/lh_nibble2ascii.sv | 28 ++
 rtl/lh_digest_hex_reader.sv | 100 ++++++++++
 tb/tb_lh_digest_hex_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lh_pkg.sv
// lh_pkg: shared definitions for the light hash output path.
//   LH_DIGEST_W  width of a digest word
//   LH_IV        initial value of the hash core (also a handy known digest)
//   ASCII_*      character constants used by the hex printers
//   lh_rd_state_t  state encoding of the digest hex reader
package lh_pkg;

    localparam int          LH_DIGEST_W = 64;
    localparam logic [63:0] LH_IV       = 64'h34550F14DAC02BEE;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        NL   = 2'd2
    } lh_rd_state_t;

endpackage

// File: rtl/lh_nibble2ascii.sv
// lh_nibble2ascii: combinational conversion of one nibble to its ASCII hex
// character.
//   UPPERCASE  1: 'A'..'F' for 10..15, 0: 'a'..'f'
//   i_nibble   4-bit value
//   o_char     ASCII character
module lh_nibble2ascii
    import lh_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    logic [7:0] w_nib8;
    logic [7:0] w_alpha_base;

    assign w_nib8       = {4'h0, i_nibble};
    assign w_alpha_base = UPPERCASE ? ASCII_UA : ASCII_LA;

    always_comb begin
        o_char = ASCII_0 + w_nib8;
        if (i_nibble >= 4'd10) begin
            o_char = w_alpha_base + (w_nib8 - 8'd10);
        end
    end

endmodule

// File: rtl/lh_digest_hex_reader.sv
// lh_digest_hex_reader: captures a digest from the hash core and streams it
// as 16 ASCII hex characters (MS nibble first), optionally followed by LF,
// over a valid/ready byte interface.
//   clk, rst       clock, asynchronous active-high reset
//   digest         digest word, sampled when a capture happens
//   digest_ready   digest strobe from the hash core
//   out_char       current character (0 when idle)
//   out_valid      out_char is valid
//   out_ready      sink accepts out_char this cycle
//   busy           a digest is held and not yet fully transferred
//   err_overrun    one-cycle pulse when a strobed digest was dropped
module lh_digest_hex_reader
    import lh_pkg::*;
#(
    parameter bit UPPERCASE      = 1'b1,
    parameter bit APPEND_NEWLINE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LH_DIGEST_W-1:0] digest,
    input  logic                   digest_ready,
    output logic [7:0]             out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err_overrun
);

    lh_rd_state_t           r_state;
    logic [LH_DIGEST_W-1:0] r_sreg;
    logic [3:0]             r_idx;
    logic                   r_err;

    logic [7:0] w_hex_char;
    logic       w_hs;
    logic       w_final_hs;
    logic       w_capture;

    lh_nibble2ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_nib (
        .i_nibble(r_sreg[LH_DIGEST_W-1 -: 4]),
        .o_char  (w_hex_char)
    );

    assign w_hs = (r_state != IDLE) && out_ready;

    // The transfer that ends the current digest: LF if enabled, else the
    // last hex character. A new digest arriving on this edge is taken
    // straight into HEX so consecutive digests have no idle gap.
    assign w_final_hs = w_hs &&
                        ((r_state == NL) ||
                         ((r_state == HEX) && (r_idx == 4'hF) && !APPEND_NEWLINE));

    assign w_capture = digest_ready && ((r_state == IDLE) || w_final_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_idx   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            // Any strobe that cannot be captured while busy is dropped.
            r_err <= digest_ready && !w_capture && (r_state != IDLE);

            if (w_capture) begin
                r_state <= HEX;
                r_sreg  <= digest;
                r_idx   <= 4'd0;
            end else if (w_hs) begin
                case (r_state)
                    HEX: begin
                        r_sreg <= {r_sreg[LH_DIGEST_W-5:0], 4'h0};
                        r_idx  <= r_idx + 4'd1;
                        if (r_idx == 4'hF) begin
                            r_state <= APPEND_NEWLINE ? NL : IDLE;
                        end
                    end
                    NL:      r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        case (r_state)
            HEX:     out_char = w_hex_char;
            NL:      out_char = ASCII_LF;
            default: out_char = 8'h00;
        endcase
    end

    assign out_valid   = (r_state != IDLE);
    assign busy        = (r_state != IDLE);
    assign err_overrun = r_err;

endmodule

// File: tb/tb_lh_digest_hex_reader.sv
module tb_lh_digest_hex_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] digest;
    logic        digest_ready;
    logic        out_ready;

    logic [7:0]  out_char_a, out_char_b;
    logic        out_valid_a, out_valid_b;
    logic        busy_a, busy_b;
    logic        err_a, err_b;

    always #5 clk = ~clk;

    // A: uppercase with LF; B: lowercase, no LF. Both see the same stimulus.
    lh_digest_hex_reader u_dut_a (
        .clk(clk), .rst(rst), .digest(digest), .digest_ready(digest_ready),
        .out_char(out_char_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .busy(busy_a), .err_overrun(err_a)
    );

    lh_digest_hex_reader #(.UPPERCASE(1'b0), .APPEND_NEWLINE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .digest(digest), .digest_ready(digest_ready),
        .out_char(out_char_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .busy(busy_b), .err_overrun(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of characters still owed by each DUT.
    byte qa[$];
    byte qb[$];
    bit  exp_err_a, exp_err_b;
    byte got_a[$];
    byte got_b[$];

    string hex_u = "0123456789ABCDEF";
    string hex_l = "0123456789abcdef";

    typedef struct {
        logic [63:0] d;
        string       txt_a;
        string       txt_b;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic string mk_text(input logic [63:0] d, input bit upper, input bit nl);
        string s = "";
        for (int i = 15; i >= 0; i--) begin
            int n = int'(d[i*4 +: 4]);
            s = {s, upper ? hex_u.substr(n, n) : hex_l.substr(n, n)};
        end
        if (nl) s = {s, "\n"};
        return s;
    endfunction

    task automatic push_text(input string s, input bit to_a);
        for (int i = 0; i < s.len(); i++) begin
            if (to_a) qa.push_back(s[i]);
            else      qb.push_back(s[i]);
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cycle(input logic dr, input logic [63:0] d, input logic rdy);
        bit  hs_a, hs_b, acc_a, acc_b;
        byte tmp;
        digest_ready = dr;
        digest       = d;
        out_ready    = rdy;

        hs_a  = (qa.size() > 0) && rdy;
        acc_a = dr && ((qa.size() == 0) || (hs_a && qa.size() == 1));
        exp_err_a = dr && !acc_a;
        if (hs_a) begin
            got_a.push_back(out_char_a);
            tmp = qa.pop_front();
        end
        if (acc_a) push_text(mk_text(d, 1'b1, 1'b1), 1'b1);

        hs_b  = (qb.size() > 0) && rdy;
        acc_b = dr && ((qb.size() == 0) || (hs_b && qb.size() == 1));
        exp_err_b = dr && !acc_b;
        if (hs_b) begin
            got_b.push_back(out_char_b);
            tmp = qb.pop_front();
        end
        if (acc_b) push_text(mk_text(d, 1'b0, 1'b0), 1'b0);

        @(posedge clk);
        #1;
        chk("valid_a", 64'(out_valid_a), 64'(qa.size() > 0));
        chk("busy_a",  64'(busy_a),      64'(qa.size() > 0));
        chk("err_a",   64'(err_a),       64'(exp_err_a));
        if (qa.size() > 0) chk("char_a", 64'(out_char_a), 64'(qa[0]));
        chk("valid_b", 64'(out_valid_b), 64'(qb.size() > 0));
        chk("busy_b",  64'(busy_b),      64'(qb.size() > 0));
        chk("err_b",   64'(err_b),       64'(exp_err_b));
        if (qb.size() > 0) chk("char_b", 64'(out_char_b), 64'(qb[0]));
    endtask

    task automatic drain(input int max_cycles, input int ready_period);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0) && n < max_cycles) begin
            cycle(1'b0, 64'h0, (n % ready_period) == 0);
            n++;
        end
        chk("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic cmp_text(input string name, input string exp_a, input string exp_b);
        chk({name, "_len_a"}, 64'(got_a.size()), 64'(exp_a.len()));
        chk({name, "_len_b"}, 64'(got_b.size()), 64'(exp_b.len()));
        for (int i = 0; i < exp_a.len() && i < got_a.size(); i++)
            chk({name, "_txt_a"}, 64'(got_a[i]), 64'(exp_a[i]));
        for (int i = 0; i < exp_b.len() && i < got_b.size(); i++)
            chk({name, "_txt_b"}, 64'(got_b[i]), 64'(exp_b[i]));
        $display("seq %s: a=%0d chars b=%0d chars", name, got_a.size(), got_b.size());
    endtask

    task automatic clear_got();
        got_a.delete();
        got_b.delete();
    endtask

    initial begin
        vecs[0] = '{64'h34550F14DAC02BEE, "34550F14DAC02BEE\n", "34550f14dac02bee"};
        vecs[1] = '{64'hABCDEF00ABCDEF00, "ABCDEF00ABCDEF00\n", "abcdef00abcdef00"};
        vecs[2] = '{64'h0000000000000001, "0000000000000001\n", "0000000000000001"};
        vecs[3] = '{64'hFEDCBA9876543210, "FEDCBA9876543210\n", "fedcba9876543210"};

        rst = 1'b1; digest = '0; digest_ready = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_char_a",  64'(out_char_a),  64'h00);
        chk("rst_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_busy_a",  64'(busy_a),      64'd0);
        chk("rst_err_a",   64'(err_a),       64'd0);
        chk("rst_valid_b", 64'(out_valid_b), 64'd0);
        rst = 1'b0;

        // Table: full-speed stream of each digest.
        foreach (vecs[v]) begin
            clear_got();
            cycle(1'b1, vecs[v].d, 1'b1);
            drain(40, 1);
            cmp_text($sformatf("vec%0d", v), vecs[v].txt_a, vecs[v].txt_b);
        end

        // Basic stream timing: 17 transfers in 17 cycles after capture.
        clear_got();
        cycle(1'b1, 64'h34550F14DAC02BEE, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b0, 64'h0, 1'b1);
        chk("basic_busy_low", 64'(busy_a), 64'd0);
        cmp_text("basic", "34550F14DAC02BEE\n", "34550f14dac02bee");

        // Backpressure: ready 1,0,0,1,0,0,...
        clear_got();
        cycle(1'b1, 64'h34550F14DAC02BEE, 1'b0);
        drain(100, 3);
        cmp_text("backpressure", "34550F14DAC02BEE\n", "34550f14dac02bee");

        // Overrun while character 5 is pending.
        clear_got();
        cycle(1'b1, 64'h0123456789ABCDEF, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 1'b1);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("overrun_pulse", 64'(err_a), 64'd1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("overrun_clear", 64'(err_a), 64'd0);
        drain(40, 1);
        cmp_text("overrun", "0123456789ABCDEF\n", "0123456789abcdef");

        // Back-to-back: second digest during the LF handshake of A.
        clear_got();
        cycle(1'b1, 64'h34550F14DAC02BEE, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 64'h0, 1'b1);
        cycle(1'b1, 64'hFEDCBA9876543210, 1'b1);
        chk("b2b_no_err", 64'(err_a), 64'd0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 64'h0, 1'b1);
        chk("b2b_gapless", 64'(got_a.size()), 64'd34);
        drain(40, 1);
        cmp_text("b2b", "34550F14DAC02BEE\nFEDCBA9876543210\n",
                 "34550f14dac02beefedcba9876543210");

        // Reset in the middle of a stream.
        clear_got();
        cycle(1'b1, 64'h0123456789ABCDEF, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 64'h0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_char_a",  64'(out_char_a),  64'h00);
        chk("mid_rst_valid_a", 64'(out_valid_a), 64'd0);
        chk("mid_rst_busy_a",  64'(busy_a),      64'd0);
        chk("mid_rst_err_a",   64'(err_a),       64'd0);
        chk("mid_rst_valid_b", 64'(out_valid_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete();
        clear_got();
        cycle(1'b1, 64'h1, 1'b1);
        drain(40, 1);
        cmp_text("after_rst", "0000000000000001\n", "0000000000000001");

        // Random traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 9) == 0),
                  {$urandom(), $urandom()},
                  ($urandom_range(0, 9) < 7));
        end
        drain(200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
